instr_prefetch_buffer: RTL and testbench

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/instr_prefetch_buffer_if.sv | 39 +++
 rtl/instr_prefetch_buffer.sv | 94 +++++++++
 tb/tb_instr_prefetch_buffer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_buffer_if.sv
// Bundle of fetch-side, decode-side and status signals of the prefetch buffer.
// Handshakes:
//   fetch side : a pair {in_pc, in_instr} is offered when in_valid = 1; the buffer
//                has no ready back to fetch. fetch_en grants PC advance and keeps
//                one slot free for the fetch already in flight.
//   decode side: the head entry transfers on a rising edge where
//                out_valid = 1 and out_ready = 1 (and no flush).
//                out_valid never drops without a transfer, except on flush or reset.
interface instr_prefetch_buffer_if #(
    parameter int PC_WIDTH = 8,
    parameter int DEPTH    = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic [PC_WIDTH-1:0] in_pc;
    logic [15:0]         in_instr;
    logic                fetch_en;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [15:0]         out_instr;
    logic [CW-1:0]       count;
    logic                overflow;
    logic                discard_state;  // 0 = IDLE, 1 = DROP

    // Driven by the fetch stage / decode stage environment.
    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  fetch_en, out_valid, out_pc, out_instr, count, overflow, discard_state
    );

    // The buffer itself.
    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output fetch_en, out_valid, out_pc, out_instr, count, overflow, discard_state
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// In-order prefetch FIFO of {pc, instr} pairs between fetch and decode.
// Show-ahead head, one slot reserved for the in-flight fetch, flush clears the
// queue and a one-cycle discard window drops the wrong-path fetch in flight.
module instr_prefetch_buffer #(
    parameter int PC_WIDTH = 8,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_prefetch_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        DROP = 1'b1
    } discard_t;

    discard_t            state_q;
    discard_t            state_d;
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [15:0]         instr_mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count_q;
    logic                overflow_q;
    logic                full;
    logic                push_req;
    logic                push;
    logic                pop;

    assign full     = (count_q == CW'(DEPTH));
    assign push_req = bus.in_valid && !bus.flush && (state_q == IDLE);
    assign pop      = (count_q != '0) && bus.out_ready && !bus.flush;
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push     = push_req && (!full || pop);

    assign bus.out_valid     = (count_q != '0);
    assign bus.out_pc        = pc_mem[rd_ptr];
    assign bus.out_instr     = instr_mem[rd_ptr];
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.fetch_en      = (count_q < CW'(DEPTH - 1)) && !bus.flush;
    assign bus.discard_state = state_q;

    // Discard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Discard next state: flush opens a one-cycle drop window, repeated flush extends it.
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = bus.flush ? DROP : IDLE;
            DROP:    state_d = bus.flush ? DROP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entry storage; contents need no reset because out_valid gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.in_pc;
            instr_mem[wr_ptr] <= bus.in_instr;
        end
    end

    // Pointers and occupancy; flush empties the queue and overrides any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Sticky overflow: set when an accepted-looking push finds the buffer full with no pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          overflow_q <= 1'b0;
        else if (push_req && full && !pop)   overflow_q <= 1'b1;
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based model of the buffer behaviour.
module tb_instr_prefetch_buffer;
    localparam int PC_WIDTH = 8;
    localparam int DEPTH    = 4;
    localparam int EW       = PC_WIDTH + 16;

    logic clk;
    logic rst_n;

    instr_prefetch_buffer_if #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) bus ();

    instr_prefetch_buffer #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [EW-1:0] exp_q[$];
    bit            m_drop;
    bit            m_ovf;

    int n_checks;
    int n_pass;

    // Driver: present inputs for the next rising edge.
    task automatic drive(input bit iv, input logic [PC_WIDTH-1:0] pc, input bit fl, input bit rdy);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = 16'($urandom);
        bus.flush     = fl;
        bus.out_ready = rdy;
    endtask

    // One clock: apply the model rules to the presented inputs, then settle to the falling edge.
    task automatic tick();
        bit            fl;
        bit            iv;
        bit            rdy;
        logic [EW-1:0] e;
        logic [EW-1:0] dropped;
        fl  = bus.flush;
        iv  = bus.in_valid;
        rdy = bus.out_ready;
        e   = {bus.in_pc, bus.in_instr};
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            m_drop = 1'b1;
        end else begin
            if (rdy && exp_q.size() > 0) dropped = exp_q.pop_front();
            if (iv && !m_drop) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(e);
                else                      m_ovf = 1'b1;
            end
            m_drop = 1'b0;
        end
        @(negedge clk);
    endtask

    // Reset pulse aligned to the falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_drop = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic fill(input logic [PC_WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, base + PC_WIDTH'(i), 0, 0);
            tick();
        end
        drive(0, '0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        #1;
        n_checks++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", bus.overflow); else n_pass++;
        n_checks++; if (bus.discard_state !== 1'b0) $display("FAIL reset_state got %b want 0", bus.discard_state); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.fetch_en !== 1'b1) $display("FAIL reset_fetch_en got %b want 1", bus.fetch_en); else n_pass++;
        drive(1, 8'h5a, 0, 0);
        tick();
        n_checks++; if (bus.count !== 3'd1 || bus.out_pc !== 8'h5a) $display("FAIL reset_first_push got count=%0d pc=%h want count=1 pc=5a", bus.count, bus.out_pc); else n_pass++;
        apply_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            drive(1, PC_WIDTH'(i), 0, 1);
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== PC_WIDTH'(i)) $display("FAIL stream_pc got v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, PC_WIDTH'(i)); else n_pass++;
            n_checks++; if (bus.count !== 3'd1) $display("FAIL stream_count got %0d want 1", bus.count); else n_pass++;
        end
        drive(0, '0, 0, 1);
        tick();
        n_checks++; if (bus.count !== 3'd0) $display("FAIL stream_drain got %0d want 0", bus.count); else n_pass++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.fetch_en !== (i < 3)) $display("FAIL bp_fetch_en at count %0d got %b want %b", i, bus.fetch_en, (i < 3)); else n_pass++;
            drive(1, PC_WIDTH'(i), 0, 0);
            tick();
        end
        n_checks++; if (bus.count !== 3'd4) $display("FAIL bp_count got %0d want 4", bus.count); else n_pass++;
        n_checks++; if (bus.fetch_en !== 1'b0) $display("FAIL bp_fetch_en_full got %b want 0", bus.fetch_en); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL bp_overflow got %b want 0", bus.overflow); else n_pass++;
        drive(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_pc !== PC_WIDTH'(i) || bus.out_instr !== exp_q[0][15:0]) $display("FAIL bp_drain got pc=%h instr=%h want pc=%h instr=%h", bus.out_pc, bus.out_instr, PC_WIDTH'(i), exp_q[0][15:0]); else n_pass++;
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [PC_WIDTH-1:0] order [4];
        order[0] = 8'h31; order[1] = 8'h32; order[2] = 8'h33; order[3] = 8'h10;
        fill(8'h30, 4);
        drive(1, 8'h10, 0, 1);
        tick();
        n_checks++; if (bus.count !== 3'd4) $display("FAIL full_pp_count got %0d want 4", bus.count); else n_pass++;
        n_checks++; if (bus.out_pc !== 8'h31) $display("FAIL full_pp_head got %h want 31", bus.out_pc); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL full_pp_overflow got %b want 0", bus.overflow); else n_pass++;
        drive(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_pc !== order[i]) $display("FAIL full_pp_order got %h want %h", bus.out_pc, order[i]); else n_pass++;
            tick();
        end
    endtask

    task automatic test_overflow();
        fill(8'h50, 4);
        drive(1, 8'h40, 0, 0);
        tick();
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.overflow); else n_pass++;
        n_checks++; if (bus.count !== 3'd4 || bus.out_pc !== 8'h50) $display("FAIL ovf_unchanged got count=%0d pc=%h want count=4 pc=50", bus.count, bus.out_pc); else n_pass++;
        drive(0, '0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        drive(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_pc !== 8'h50 + PC_WIDTH'(i)) $display("FAIL ovf_drain got %h want %h", bus.out_pc, 8'h50 + PC_WIDTH'(i)); else n_pass++;
            tick();
        end
        n_checks++; if (bus.count !== 3'd0) $display("FAIL ovf_tail_dropped got count %0d want 0", bus.count); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.overflow); else n_pass++;
        apply_reset();
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_reset got %b want 0", bus.overflow); else n_pass++;
    endtask

    task automatic test_flush();
        fill(8'h01, 3);
        drive(1, 8'h07, 1, 1);
        #1;
        n_checks++; if (bus.fetch_en !== 1'b0) $display("FAIL flush_fetch_en got %b want 0", bus.fetch_en); else n_pass++;
        tick();
        n_checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) $display("FAIL flush_clear got count=%0d v=%b want 0 0", bus.count, bus.out_valid); else n_pass++;
        n_checks++; if (bus.discard_state !== 1'b1) $display("FAIL flush_drop got %b want 1", bus.discard_state); else n_pass++;
        drive(1, 8'h08, 0, 0);
        tick();
        n_checks++; if (bus.count !== 3'd0) $display("FAIL flush_discard got count %0d want 0", bus.count); else n_pass++;
        drive(1, 8'h20, 0, 0);
        tick();
        n_checks++; if (bus.count !== 3'd1 || bus.out_pc !== 8'h20) $display("FAIL flush_resume got count=%0d pc=%h want 1 20", bus.count, bus.out_pc); else n_pass++;
        drive(0, '0, 0, 1);
        tick();
    endtask

    task automatic test_async_reset();
        fill(8'h60, 2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) $display("FAIL areset_count got count=%0d v=%b want 0 0", bus.count, bus.out_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        fill(8'h70, 2);
        drive(0, '0, 1, 0);
        tick();
        drive(0, '0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.discard_state !== 1'b0) $display("FAIL areset_state got %b want 0", bus.discard_state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        #1;
        n_checks++; if (bus.fetch_en !== 1'b1) $display("FAIL areset_fetch_en got %b want 1", bus.fetch_en); else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 9) < 7, PC_WIDTH'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
            tick();
            n_checks++; if (bus.count !== 3'(exp_q.size())) $display("FAIL rand_count cyc %0d got %0d want %0d", c, bus.count, exp_q.size()); else n_pass++;
            n_checks++; if (bus.overflow !== m_ovf) $display("FAIL rand_overflow cyc %0d got %b want %b", c, bus.overflow, m_ovf); else n_pass++;
            n_checks++; if (bus.discard_state !== m_drop) $display("FAIL rand_state cyc %0d got %b want %b", c, bus.discard_state, m_drop); else n_pass++;
            n_checks++; if (bus.fetch_en !== ((exp_q.size() < DEPTH - 1) && !bus.flush)) $display("FAIL rand_fetch_en cyc %0d got %b", c, bus.fetch_en); else n_pass++;
            if (exp_q.size() > 0) begin
                n_checks++; if ({bus.out_pc, bus.out_instr} !== exp_q[0]) $display("FAIL rand_head cyc %0d got %h want %h", c, {bus.out_pc, bus.out_instr}, exp_q[0]); else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_drop   = 1'b0;
        m_ovf    = 1'b0;
        rst_n    = 1'b0;
        drive(0, '0, 0, 0);
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_overflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
